// File: rtl/unidad_de_busqueda.sv
// -----------------------------------------------------------------------------
// unidad_de_busqueda
//   Instruction-fetch stage of the RV32I core. Holds the program counter,
//   reads one instruction word per instruction over a req/ack handshake,
//   latches it in the instruction register (IR) and, once execute reports
//   completion, advances the PC according to the control unit's selectors.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   mem_req/mem_addr    instruction read request and address (= pc)
//   mem_ack/mem_rdata   read acknowledge and instruction word
//   instr               instruction register
//   opcode/funct3/funct7 IR fields feeding Unidad_de_Control
//   pc, pc_plus4        address of the instruction in IR and its link value
//   inst_valid          IR holds an instruction not yet retired
//   exec_done           execute/write-back finished the instruction in IR
//   pcsel, jrj, taken   next-PC selectors (00 +4, 01 branch, 10 JAL, 11 +4;
//                       jrj selects JALR and overrides pcsel)
//   imm, jalr_target    B/J offset and rs1+imm from the ALU
//   retired             retired-instruction counter (wraps)
//   misalign            sticky: a computed next PC was not word-aligned
// -----------------------------------------------------------------------------
module unidad_de_busqueda #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  output logic               mem_req,
  output logic [31:0]        mem_addr,
  input  logic               mem_ack,
  input  logic [31:0]        mem_rdata,
  output logic [31:0]        instr,
  output logic [6:0]         opcode,
  output logic [2:0]         funct3,
  output logic [6:0]         funct7,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic               inst_valid,
  input  logic               exec_done,
  input  logic [1:0]         pcsel,
  input  logic               jrj,
  input  logic               taken,
  input  logic signed [31:0] imm,
  input  logic [31:0]        jalr_target,
  output logic [31:0]        retired,
  output logic               misalign
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t      state, state_nx;
  logic [31:0] next_pc;
  logic        next_misaligned;

  // Next-PC selection; all sums wrap modulo 2^32. The offset is signed, so
  // backward branches come out of the same adder as forward ones.
  function automatic logic [31:0] calc_next_pc(
    input logic [31:0]        pc_c,
    input logic [1:0]         sel,
    input logic               jr,
    input logic               tk,
    input logic signed [31:0] off,
    input logic [31:0]        jt
  );
    logic signed [31:0] base;
    base = signed'(pc_c);
    if (jr)
      return jt & 32'hFFFF_FFFE;
    else if (sel == 2'b10 || (sel == 2'b01 && tk))
      return unsigned'(base + off);
    else
      return pc_c + 32'd4;
  endfunction

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

  assign next_pc         = calc_next_pc(pc, pcsel, jrj, taken, imm, jalr_target);
  assign next_misaligned = is_misaligned(next_pc);

  // Handshake outputs come from the state register only.
  assign mem_req    = (state == FETCH);
  assign inst_valid = (state == ISSUE);
  assign mem_addr   = pc;
  assign pc_plus4   = pc + 32'd4;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = FETCH;
      FETCH: if (mem_ack) state_nx = ISSUE;
      ISSUE: if (exec_done) state_nx = next_misaligned ? HALT : FETCH;
      HALT:  state_nx = HALT;
      default: state_nx = IDLE;
    endcase
  end

  // --- fetch / retire boundary: IR captured in FETCH, PC advanced in ISSUE ---
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      instr    <= NOP;
      retired  <= 32'd0;
      misalign <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == FETCH && mem_ack)
        instr <= mem_rdata;
      if (state == ISSUE && exec_done) begin
        pc      <= next_pc;
        retired <= retired + 32'd1;
        if (next_misaligned)
          misalign <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_unidad_de_busqueda.sv
module tb_unidad_de_busqueda;

  logic               clk = 1'b0;
  logic               rst;
  logic               mem_req;
  logic [31:0]        mem_addr;
  logic               mem_ack;
  logic [31:0]        mem_rdata;
  logic [31:0]        instr;
  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  logic [31:0]        pc;
  logic [31:0]        pc_plus4;
  logic               inst_valid;
  logic               exec_done;
  logic [1:0]         pcsel;
  logic               jrj;
  logic               taken;
  logic signed [31:0] imm;
  logic [31:0]        jalr_target;
  logic [31:0]        retired;
  logic               misalign;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] exp_ret;

  unidad_de_busqueda #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr(instr), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .pc(pc), .pc_plus4(pc_plus4), .inst_valid(inst_valid),
    .exec_done(exec_done), .pcsel(pcsel), .jrj(jrj), .taken(taken),
    .imm(imm), .jalr_target(jalr_target),
    .retired(retired), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle fetch with an immediate acknowledge (FETCH -> ISSUE).
  task automatic fetch(input logic [31:0] word);
    mem_ack   = 1'b1;
    mem_rdata = word;
    tick();
    mem_ack   = 1'b0;
  endtask

  // Retire the instruction in IR with the given next-PC selectors.
  task automatic retire(input logic [1:0] sel, input logic jr, input logic tk,
                        input logic [31:0] off, input logic [31:0] jt);
    pcsel = sel; jrj = jr; taken = tk; imm = signed'(off); jalr_target = jt;
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    pcsel = 2'b00; jrj = 1'b0; taken = 1'b0;
    exp_ret = exp_ret + 32'd1;
  endtask

  initial begin
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = 32'h0; exec_done = 1'b0;
    pcsel = 2'b00; jrj = 1'b0; taken = 1'b0; imm = 32'sd0; jalr_target = 32'h0;
    exp_ret = 32'd0;
    #1;
    // Reset state
    chk("rst_mem_req",   {31'd0, mem_req},    32'd0);
    chk("rst_valid",     {31'd0, inst_valid}, 32'd0);
    chk("rst_ir",        instr,               32'h13);
    chk("rst_pc",        pc,                  32'h0);
    chk("rst_retired",   retired,             32'd0);
    chk("rst_misalign",  {31'd0, misalign},   32'd0);

    tick();
    rst = 1'b0;
    tick();                                   // IDLE -> FETCH
    chk("f0_req",   {31'd0, mem_req},    32'd1);
    chk("f0_addr",  mem_addr,            32'h0);
    chk("f0_valid", {31'd0, inst_valid}, 32'd0);

    // Straight-line fetch with same-cycle ack
    fetch(32'hfe010113);
    chk("i0_valid",  {31'd0, inst_valid}, 32'd1);
    chk("i0_ir",     instr,               32'hfe010113);
    chk("i0_opcode", {25'd0, opcode},     32'h13);
    chk("i0_funct3", {29'd0, funct3},     32'd0);
    chk("i0_funct7", {25'd0, funct7},     32'h7f);
    chk("i0_req",    {31'd0, mem_req},    32'd0);
    chk("i0_pc4",    pc_plus4,            32'h4);

    // Retire with exec_done then held high through the following wait states
    pcsel = 2'b00; exec_done = 1'b1;
    tick();
    exp_ret = exp_ret + 32'd1;
    chk("r0_pc",      pc,      32'h4);
    chk("r0_retired", retired, exp_ret);

    // Memory wait: ack delayed 3 cycles, so 4 FETCH cycles in total
    for (int i = 0; i < 3; i++) begin
      chk("wait_req",     {31'd0, mem_req},    32'd1);
      chk("wait_addr",    mem_addr,            32'h4);
      chk("wait_valid",   {31'd0, inst_valid}, 32'd0);
      chk("wait_retired", retired,             exp_ret);
      tick();
    end
    chk("wait_req4", {31'd0, mem_req}, 32'd1);
    exec_done = 1'b0;
    fetch(32'h03c0006f);
    chk("wait_ir",    instr,               32'h03c0006f);
    chk("wait_valid", {31'd0, inst_valid}, 32'd1);

    // JAL from 0x4 to 0x40
    retire(2'b10, 1'b0, 1'b0, 32'h3c, 32'h0);
    chk("j40_pc", pc, 32'h40);

    // Branch at 0x40, stall one ISSUE cycle first
    fetch(32'hfef710e3);
    chk("br_opcode", {25'd0, opcode}, 32'h63);
    chk("br_funct3", {29'd0, funct3}, 32'd1);
    tick();
    chk("br_hold_pc",    pc,                  32'h40);
    chk("br_hold_valid", {31'd0, inst_valid}, 32'd1);
    chk("br_hold_ir",    instr,               32'hfef710e3);
    retire(2'b01, 1'b0, 1'b1, 32'hFFFF_FFE0, 32'h0);
    chk("br_taken_pc", pc, 32'h20);
    fetch(32'h0200006f);
    retire(2'b10, 1'b0, 1'b0, 32'h20, 32'h0);
    chk("back40_pc", pc, 32'h40);
    fetch(32'hfef710e3);
    retire(2'b01, 1'b0, 1'b0, 32'hFFFF_FFE0, 32'h0);
    chk("br_nt_pc", pc, 32'h44);

    // JAL to 0x100, then JAL +12, then JALR overriding pcsel
    fetch(32'h0bc0006f);
    retire(2'b10, 1'b0, 1'b0, 32'hbc, 32'h0);
    chk("j100_pc", pc, 32'h100);
    fetch(32'h00c000ef);
    chk("jal_pc4", pc_plus4, 32'h104);
    retire(2'b10, 1'b0, 1'b0, 32'hc, 32'h0);
    chk("jal_pc", pc, 32'h10c);
    fetch(32'h000080e7);
    retire(2'b10, 1'b1, 1'b0, 32'h1000, 32'h205);
    chk("jalr_pc", pc, 32'h204);

    // Wrap-around
    fetch(32'h000080e7);
    retire(2'b00, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFC);
    chk("wrap_setup_pc", pc, 32'hFFFF_FFFC);
    fetch(32'h00000013);
    chk("wrap_pc4", pc_plus4, 32'h0);
    retire(2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("wrap_pc", pc, 32'h0);

    // Reserved pcsel = 11 and untaken-flag branch with taken ignored
    fetch(32'h00000013);
    retire(2'b11, 1'b0, 1'b1, 32'h40, 32'h0);
    chk("sel11_pc", pc, 32'h4);
    chk("sel11_retired", retired, exp_ret);

    // Misalignment: back to 0, then JAL +2
    fetch(32'h00000013);
    retire(2'b10, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0);
    chk("mis_setup_pc", pc, 32'h0);
    fetch(32'h0020006f);
    retire(2'b10, 1'b0, 1'b0, 32'h2, 32'h0);
    chk("mis_flag",  {31'd0, misalign},   32'd1);
    chk("mis_req",   {31'd0, mem_req},    32'd0);
    chk("mis_valid", {31'd0, inst_valid}, 32'd0);
    mem_ack = 1'b1; exec_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_req",     {31'd0, mem_req},    32'd0);
      chk("halt_valid",   {31'd0, inst_valid}, 32'd0);
      chk("halt_retired", retired,             exp_ret);
      chk("halt_flag",    {31'd0, misalign},   32'd1);
    end
    mem_ack = 1'b0; exec_done = 1'b0;

    // Reset leaves HALT
    rst = 1'b1;
    #1;
    chk("hrst_pc",       pc,                32'h0);
    chk("hrst_misalign", {31'd0, misalign}, 32'd0);
    chk("hrst_retired",  retired,           32'd0);
    exp_ret = 32'd0;
    tick();
    rst = 1'b0;
    tick();
    chk("hrst_fetch", {31'd0, mem_req}, 32'd1);
    fetch(32'h00100093);
    retire(2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("pre_mid_pc", pc, 32'h4);
    chk("pre_mid_retired", retired, 32'd1);

    // Reset mid-fetch with a late ack arriving across the reset
    tick();
    chk("mid_waiting", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hdeadbeef;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_pc",      pc,               32'h0);
    chk("mid_ir",      instr,            32'h13);
    chk("mid_retired", retired,          32'd0);
    chk("mid_req",     {31'd0, mem_req}, 32'd0);
    tick();
    rst = 1'b0;
    tick();                                   // IDLE -> FETCH, stale ack ignored
    chk("post_ir",   instr,            32'h13);
    chk("post_req",  {31'd0, mem_req}, 32'd1);
    chk("post_addr", mem_addr,         32'h0);
    tick();
    mem_ack = 1'b0;
    chk("post_fetch_ir", instr,               32'hdeadbeef);
    chk("post_valid",    {31'd0, inst_valid}, 32'd1);
    chk("post_retired",  retired,             32'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
